fft64_peak_detect: RTL and testbench

// - Streaming spectrum analyser directly downstream of fft64; consumes its valid/xr/xi bin stream.
// - Computes per-bin squared magnitude and tracks the strongest bin over each 64-bin frame.
// - Accumulates total frame energy.
// - Emits one result pulse per frame for control/detection logic.

---
 rtl/fft64_pkg.sv | 15 +
 rtl/fft64_cmag2.sv | 45 ++++
 rtl/fft64_peak_detect.sv | 164 ++++++++++++++++
 tb/tb_fft64_peak_detect.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fft64_pkg.sv
// Shared constants and types for the fft64 spectrum-analysis slice.
// Widths follow the fft64 output format (11-bit signed bins, 64 per frame).
package fft64_pkg;

   localparam int FFT_N  = 64;
   localparam int FFT_DW = 11;
   localparam int FFT_IW = 6;
   localparam int PWR_W  = 2*FFT_DW;
   localparam int EN_W   = PWR_W+FFT_IW;

   typedef logic signed [FFT_DW-1:0] sample_t;
   typedef logic [PWR_W-1:0]         pwr_t;
   typedef logic [EN_W-1:0]          en_t;

endpackage

// File: rtl/fft64_cmag2.sv
// Registered squared magnitude of one complex bin.
// Carries the bin index and valid alongside the power, latency 1.
module fft64_cmag2
   import fft64_pkg::*;
#(
   parameter  int DW = FFT_DW,
   parameter  int IW = FFT_IW,
   localparam int PW = 2*DW
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 valid_i,
   input  logic signed [DW-1:0] xr,
   input  logic signed [DW-1:0] xi,
   input  logic [IW-1:0]        idx_i,
   output logic [PW-1:0]        pwr_o,
   output logic                 valid_o,
   output logic [IW-1:0]        idx_o
);

   logic signed [PW-1:0] xr_w;
   logic signed [PW-1:0] xi_w;
   logic [PW-1:0]        pwr_d;

   assign xr_w  = {{DW{xr[DW-1]}}, xr};
   assign xi_w  = {{DW{xi[DW-1]}}, xi};
   // (-2^(DW-1))^2 * 2 = 2^(2DW-1): the top bit is a magnitude bit here
   assign pwr_d = xr_w*xr_w + xi_w*xi_w;

   // stage-1 register: power, index and valid move together
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         valid_o <= 1'b0;
         pwr_o   <= '0;
         idx_o   <= '0;
      end else begin
         valid_o <= valid_i;
         if (valid_i) begin
            pwr_o <= pwr_d;
            idx_o <= idx_i;
         end
      end
   end

endmodule

// File: rtl/fft64_peak_detect.sv
// Per-frame peak bin, peak power and total energy of the fft64 stream.
// FFT_PEAK_THRESH_EN adds a count of bins whose power exceeds thresh.
module fft64_peak_detect
   import fft64_pkg::*;
#(
   parameter  int DW    = FFT_DW,
   parameter  int NBINS = FFT_N,
   parameter  int IW    = FFT_IW,
   localparam int PW    = 2*DW,
   localparam int EW    = PW+IW
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 valid_i,
   input  logic signed [DW-1:0] xr,
   input  logic signed [DW-1:0] xi,
   input  logic [PW-1:0]        thresh,
   output logic                 peak_valid,
   output logic [IW-1:0]        peak_idx,
   output logic [PW-1:0]        peak_pwr,
   output logic [EW-1:0]        frame_energy,
   output logic [IW:0]          above_cnt
);

   localparam logic [IW-1:0] LAST = IW'(NBINS-1);

   logic [IW-1:0] bin_cnt;
   logic [PW-1:0] s1_pwr;
   logic          s1_valid;
   logic [IW-1:0] s1_idx;
   logic          s1_first;

   logic [PW-1:0] run_max;
   logic [IW-1:0] run_idx;
   logic [EW-1:0] run_en;
   logic          s2_last;

   logic [PW-1:0] nxt_max;
   logic [IW-1:0] nxt_idx;
   logic [EW-1:0] nxt_en;

   // arrival-order bin numbering; gaps simply hold the count
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         bin_cnt <= '0;
      else if (valid_i)
         bin_cnt <= bin_cnt + 1'b1;
   end

   fft64_cmag2 #(
      .DW (DW),
      .IW (IW)
   ) u_cmag2 (
      .CLK     (CLK),
      .RST     (RST),
      .valid_i (valid_i),
      .xr      (xr),
      .xi      (xi),
      .idx_i   (bin_cnt),
      .pwr_o   (s1_pwr),
      .valid_o (s1_valid),
      .idx_o   (s1_idx)
   );

   assign s1_first = (s1_idx == '0);

   // bin 0 restarts the frame; later bins replace only on strictly greater
   always_comb begin
      nxt_max = run_max;
      nxt_idx = run_idx;
      nxt_en  = run_en;
      unique case (1'b1)
         s1_first: begin
            nxt_max = s1_pwr;
            nxt_idx = '0;
            nxt_en  = EW'(s1_pwr);
         end
         default: begin
            if (s1_pwr > run_max) begin
               nxt_max = s1_pwr;
               nxt_idx = s1_idx;
            end
            nxt_en = run_en + EW'(s1_pwr);
         end
      endcase
   end

   // stage-2 running state plus a flag marking the frame's final bin
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         run_max <= '0;
         run_idx <= '0;
         run_en  <= '0;
         s2_last <= 1'b0;
      end else begin
         s2_last <= s1_valid && (s1_idx == LAST);
         if (s1_valid) begin
            run_max <= nxt_max;
            run_idx <= nxt_idx;
            run_en  <= nxt_en;
         end
      end
   end

   // result registers hold until the next frame completes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         peak_valid   <= 1'b0;
         peak_idx     <= '0;
         peak_pwr     <= '0;
         frame_energy <= '0;
      end else begin
         peak_valid <= s2_last;
         if (s2_last) begin
            peak_idx     <= run_idx;
            peak_pwr     <= run_max;
            frame_energy <= run_en;
         end
      end
   end

`ifdef FFT_PEAK_THRESH_EN
   logic [PW-1:0] s1_thr;
   logic          s1_hit;
   logic [IW:0]   run_ac;
   logic [IW:0]   nxt_ac;

   assign s1_hit = (s1_pwr > s1_thr);

   // thresh travels with its bin so the compare uses the same-cycle value
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         s1_thr <= '0;
      else if (valid_i)
         s1_thr <= thresh;
   end

   // bin 0 restarts the count
   always_comb begin
      nxt_ac = run_ac + (IW+1)'(s1_hit);
      if (s1_first)
         nxt_ac = (IW+1)'(s1_hit);
   end

   // running count and its copy at frame end
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         run_ac    <= '0;
         above_cnt <= '0;
      end else begin
         if (s1_valid)
            run_ac <= nxt_ac;
         if (s2_last)
            above_cnt <= run_ac;
      end
   end
`else
   logic unused_thresh;

   assign unused_thresh = ^thresh;
   assign above_cnt     = '0;
`endif

endmodule

// File: tb/tb_fft64_peak_detect.sv
// Directed frames into fft64_peak_detect, checked by a queue scoreboard.
// Expected results are hand-computed per frame.
module tb_fft64_peak_detect;
   import fft64_pkg::*;

   logic    CLK = 1'b0;
   logic    RST = 1'b0;
   logic    valid_i = 1'b0;
   sample_t xr = '0;
   sample_t xi = '0;
   pwr_t    thresh = '0;
   logic    peak_valid;
   logic [FFT_IW-1:0] peak_idx;
   pwr_t    peak_pwr;
   en_t     frame_energy;
   logic [FFT_IW:0] above_cnt;

   fft64_peak_detect dut (
      .CLK          (CLK),
      .RST          (RST),
      .valid_i      (valid_i),
      .xr           (xr),
      .xi           (xi),
      .thresh       (thresh),
      .peak_valid   (peak_valid),
      .peak_idx     (peak_idx),
      .peak_pwr     (peak_pwr),
      .frame_energy (frame_energy),
      .above_cnt    (above_cnt)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge CLK) cyc++;

   typedef struct {
      int     idx;
      longint pwr;
      longint en;
      int     ac;
      int     edge_no;
   } exp_t;

   exp_t q[$];
   sample_t fxr[64];
   sample_t fxi[64];

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask

   function automatic int ac(input int n);
`ifdef FFT_PEAK_THRESH_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   // scoreboard monitor: every pulse must match the oldest expectation
   always @(negedge CLK) begin
      exp_t e;
      if (peak_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse edge %0d idx %0d pwr %0d",
                     cyc, peak_idx, peak_pwr);
         end else begin
            e = q.pop_front();
            chk("peak_idx", peak_idx, e.idx);
            chk("peak_pwr", peak_pwr, e.pwr);
            chk("frame_energy", frame_energy, e.en);
            chk("above_cnt", above_cnt, e.ac);
            chk("pulse_edge", cyc, e.edge_no);
         end
      end
   end

   task automatic clear_frame();
      for (int i = 0; i < 64; i++) begin
         fxr[i] = '0;
         fxi[i] = '0;
      end
   endtask

   task automatic idle(input int n);
      valid_i = 1'b0;
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic run_frame(input bit gaps, input int ei, input longint ep,
                            input longint ee, input int ea);
      for (int i = 0; i < 64; i++) begin
         if (gaps && i > 0) begin
            int n;
            n = $urandom_range(0, 3);
            repeat (n) begin
               valid_i = 1'b0;
               @(posedge CLK);
               #1;
            end
         end
         valid_i = 1'b1;
         xr = fxr[i];
         xi = fxi[i];
         @(posedge CLK);
         #1;
         if (i == 63)
            q.push_back('{ei, ep, ee, ea, cyc + 2});
      end
      valid_i = 1'b0;
      xr = '0;
      xi = '0;
   endtask

   initial begin
      int w;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_peak_valid", peak_valid, 0);
      chk("rst_peak_idx", peak_idx, 0);
      chk("rst_peak_pwr", peak_pwr, 0);
      chk("rst_frame_energy", frame_energy, 0);
      chk("rst_above_cnt", above_cnt, 0);
      RST = 1'b1;
      idle(2);
      thresh = 22'd24;

      clear_frame();
      fxr[17] = 3;
      fxi[17] = -4;
      run_frame(0, 17, 25, 25, ac(1));
      idle(5);

      clear_frame();
      fxr[5]  = 10;
      fxr[40] = 10;
      run_frame(0, 5, 100, 200, ac(2));
      idle(5);

      for (int i = 0; i < 64; i++) begin
         fxr[i] = -1024;
         fxi[i] = -1024;
      end
      run_frame(0, 0, 2097152, 134217728, ac(64));
      idle(5);

      clear_frame();
      fxr[5]  = 10;
      fxr[40] = 10;
      run_frame(1, 5, 100, 200, ac(2));
      clear_frame();
      fxi[9] = 7;
      run_frame(0, 9, 49, 49, ac(1));
      idle(5);

      clear_frame();
      fxr[1]  = 3; fxi[1]  = 4;
      fxr[8]  = 3; fxi[8]  = 4;
      fxr[60] = 3; fxi[60] = 4;
      fxr[61] = 2; fxi[61] = 4;
      run_frame(0, 1, 25, 95, ac(3));
      idle(5);

      for (int i = 0; i <= 30; i++) begin
         valid_i = 1'b1;
         xr = (i == 3) ? sample_t'(5) : sample_t'(0);
         xi = xr;
         @(posedge CLK);
         #1;
      end
      valid_i = 1'b0;
      RST = 1'b0;
      #3;
      chk("midrst_peak_idx", peak_idx, 0);
      chk("midrst_peak_pwr", peak_pwr, 0);
      chk("midrst_frame_energy", frame_energy, 0);
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b1;
      idle(2);

      clear_frame();
      fxr[2] = 1;
      fxi[2] = 1;
      run_frame(0, 2, 2, 2, ac(0));
      idle(5);

      w = 0;
      while (q.size() > 0 && w < 100) begin
         @(posedge CLK);
         w++;
      end
      #1;
      chk("pending_results", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
